primegen_seek: RTL and testbench

//  Bidirectional, loadable prime generator; successor of primegen.

---
 rtl/primegen_seek.sv | 188 ++++++++++++++++++
 tb/tb_primegen_seek.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/primegen_seek.sv
`default_nettype none
// ============================================================================
//  Module     : primegen_seek
//  Description: Loadable, bidirectional nearest-prime search with trial
//               division through a bit-serial restoring remainder unit.
//  Revision   : 1.0 - initial release
// ============================================================================
module primegen_seek #(
    parameter int WIDTH_LOG = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        go_i,
    input  logic                        load_i,
    input  logic                        down_i,
    input  logic [(1<<WIDTH_LOG)-1:0]   from_i,
    output logic                        ready_o,
    output logic                        error_o,
    output logic [(1<<WIDTH_LOG)-1:0]   res_o
);

    localparam int WIDTH = 1 << WIDTH_LOG;
    localparam logic [WIDTH_LOG-1:0] C_CNT_LAST = WIDTH_LOG'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_READY      = 3'd0,
        S_ERROR      = 3'd1,
        S_NEXT_CAND  = 3'd2,
        S_CHECK_DIVS = 3'd3,
        S_DIV        = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic                    go_prev_q;
    logic                    down_q, down_d;
    logic                    first_q, first_d;
    logic [WIDTH-1:0]        cand_q, cand_d;
    logic [WIDTH-1:0]        div_q, div_d;
    logic [2*WIDTH-1:0]      div_sq_q, div_sq_d;
    logic [WIDTH-1:0]        rem_q, rem_d;
    logic [WIDTH-1:0]        dvd_q, dvd_d;
    logic [WIDTH_LOG-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]        res_q, res_d;

    logic                    w_idle;
    logic                    w_accept;
    logic [WIDTH-1:0]        w_step;
    logic [WIDTH:0]          w_up_sum;
    logic                    w_down_low;
    logic [WIDTH:0]          w_rem_sh;
    logic [WIDTH-1:0]        w_rem_sub;
    logic [WIDTH-1:0]        w_rem_nx;
    logic [2*WIDTH-1:0]      w_div_inc;

    assign w_idle   = (state_q == S_READY) || (state_q == S_ERROR);
    assign w_accept = go_i && !go_prev_q && w_idle;

    // Once the candidate is 2 or odd, only odd values remain worth testing.
    assign w_step     = ((cand_q == WIDTH'(2)) || cand_q[0]) ? WIDTH'(2) : WIDTH'(1);
    assign w_up_sum   = {1'b0, cand_q} + {1'b0, w_step};
    assign w_down_low = {1'b0, cand_q} < ({1'b0, w_step} + (WIDTH+1)'(2));

    // Restoring remainder step: the partial remainder stays below div.
    assign w_rem_sh  = {rem_q, dvd_q[WIDTH-1]};
    assign w_rem_sub = w_rem_sh[WIDTH-1:0] - div_q;
    assign w_rem_nx  = (w_rem_sh >= {1'b0, div_q}) ? w_rem_sub : w_rem_sh[WIDTH-1:0];

    // (div+2)^2 - div^2 = 4*div + 4
    assign w_div_inc = {{(WIDTH-2){1'b0}}, div_q, 2'b00} + (2*WIDTH)'(4);

    always_comb begin
        state_d  = state_q;
        down_d   = down_q;
        first_d  = first_q;
        cand_d   = cand_q;
        div_d    = div_q;
        div_sq_d = div_sq_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        cnt_d    = cnt_q;
        res_d    = res_q;

        case (state_q)
            S_READY, S_ERROR: begin
                if (w_accept) begin
                    cand_d  = load_i ? from_i : res_q;
                    down_d  = down_i;
                    first_d = 1'b1;
                    state_d = S_NEXT_CAND;
                end
            end

            S_NEXT_CAND: begin
                first_d  = 1'b0;
                div_d    = WIDTH'(3);
                div_sq_d = (2*WIDTH)'(9);
                state_d  = S_CHECK_DIVS;
                if (first_q) begin
                    if (!down_q) begin
                        if (&cand_q) state_d = S_ERROR;
                        else         cand_d  = cand_q + WIDTH'(1);
                    end else begin
                        if (cand_q <= WIDTH'(2)) state_d = S_ERROR;
                        else                     cand_d  = cand_q - WIDTH'(1);
                    end
                end else begin
                    if (!down_q) begin
                        if (w_up_sum[WIDTH]) state_d = S_ERROR;
                        else                 cand_d  = w_up_sum[WIDTH-1:0];
                    end else begin
                        if (w_down_low) state_d = S_ERROR;
                        else            cand_d  = cand_q - w_step;
                    end
                end
            end

            S_CHECK_DIVS: begin
                if (cand_q < WIDTH'(2)) begin
                    state_d = S_NEXT_CAND;
                end else if ((cand_q == WIDTH'(2)) || (cand_q == WIDTH'(3))) begin
                    res_d   = cand_q;
                    state_d = S_READY;
                end else if (!cand_q[0]) begin
                    state_d = S_NEXT_CAND;
                end else if (div_sq_q > {{WIDTH{1'b0}}, cand_q}) begin
                    res_d   = cand_q;
                    state_d = S_READY;
                end else begin
                    rem_d   = '0;
                    dvd_d   = cand_q;
                    cnt_d   = '0;
                    state_d = S_DIV;
                end
            end

            S_DIV: begin
                rem_d = w_rem_nx;
                dvd_d = dvd_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_CNT_LAST) begin
                    if (w_rem_nx == '0) begin
                        state_d = S_NEXT_CAND;
                    end else begin
                        div_d    = div_q + WIDTH'(2);
                        div_sq_d = div_sq_q + w_div_inc;
                        state_d  = S_CHECK_DIVS;
                    end
                end
            end

            default: state_d = S_READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_READY;
            go_prev_q <= 1'b0;
            down_q    <= 1'b0;
            first_q   <= 1'b0;
            cand_q    <= '0;
            div_q     <= WIDTH'(3);
            div_sq_q  <= (2*WIDTH)'(9);
            rem_q     <= '0;
            dvd_q     <= '0;
            cnt_q     <= '0;
            res_q     <= WIDTH'(1);
        end else begin
            state_q   <= state_d;
            go_prev_q <= go_i;
            down_q    <= down_d;
            first_q   <= first_d;
            cand_q    <= cand_d;
            div_q     <= div_d;
            div_sq_q  <= div_sq_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
        end
    end

    assign ready_o = w_idle;
    assign error_o = (state_q == S_ERROR);
    assign res_o   = res_q;

endmodule
`default_nettype wire

// File: tb/tb_primegen_seek.sv
`default_nettype none
// ============================================================================
//  Module     : tb_primegen_seek
//  Description: Directed vector table for a 16-bit instance plus a full
//               base sweep of an 8-bit instance against a prime model.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_primegen_seek;

    localparam int C_BUDGET = 20000;

    logic        clk = 1'b0;
    logic        rst;
    logic        go16, load16, down16;
    logic [15:0] from16;
    logic        ready16, error16;
    logic [15:0] res16;
    logic        go8, load8, down8;
    logic [7:0]  from8;
    logic        ready8, error8;
    logic [7:0]  res8;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    primegen_seek #(.WIDTH_LOG(4)) u_dut16 (
        .clk(clk), .rst(rst), .go_i(go16), .load_i(load16), .down_i(down16),
        .from_i(from16), .ready_o(ready16), .error_o(error16), .res_o(res16)
    );

    primegen_seek #(.WIDTH_LOG(3)) u_dut8 (
        .clk(clk), .rst(rst), .go_i(go8), .load_i(load8), .down_i(down8),
        .from_i(from8), .ready_o(ready8), .error_o(error8), .res_o(res8)
    );

    typedef struct {
        bit          load;
        bit          down;
        logic [15:0] from;
        bit          exp_err;
        logic [15:0] exp_res;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start16(input string name, input bit l, input bit d, input logic [15:0] f);
        @(negedge clk);
        load16 = l; down16 = d; from16 = f; go16 = 1'b1;
        @(negedge clk);
        go16 = 1'b0; load16 = ~l; down16 = ~d; from16 = ~f;
        chk({name, "_busy_ready"}, int'(ready16), 0);
        chk({name, "_busy_error"}, int'(error16), 0);
    endtask

    task automatic wait16(input string name);
        int n = 0;
        while (!ready16 && n < C_BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_ready"}, int'(ready16), 1);
    endtask

    task automatic start8(input string name, input bit l, input bit d, input logic [7:0] f);
        @(negedge clk);
        load8 = l; down8 = d; from8 = f; go8 = 1'b1;
        @(negedge clk);
        go8 = 1'b0; load8 = ~l; down8 = ~d; from8 = ~f;
        chk({name, "_busy"}, int'(ready8), 0);
    endtask

    task automatic wait8(input string name);
        int n = 0;
        while (!ready8 && n < C_BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_ready"}, int'(ready8), 1);
    endtask

    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int k = 2; k * k <= n; k++)
            if (n % k == 0) return 1'b0;
        return 1'b1;
    endfunction

    // Nearest prime strictly above/below base within 8 bits, -1 if none.
    function automatic int ref_seek8(input int base, input bit dn);
        if (!dn) begin
            for (int p = base + 1; p <= 255; p++)
                if (is_prime(p)) return p;
        end else begin
            for (int p = base - 1; p >= 2; p--)
                if (is_prime(p)) return p;
        end
        return -1;
    endfunction

    initial begin
        vec_t vt[15];
        int   mres;
        int   exp_p;

        vt[0]  = '{1'b0, 1'b0, 16'd0,     1'b0, 16'd2};
        vt[1]  = '{1'b0, 1'b0, 16'd0,     1'b0, 16'd3};
        vt[2]  = '{1'b0, 1'b0, 16'd0,     1'b0, 16'd5};
        vt[3]  = '{1'b0, 1'b0, 16'd0,     1'b0, 16'd7};
        vt[4]  = '{1'b0, 1'b0, 16'd0,     1'b0, 16'd11};
        vt[5]  = '{1'b0, 1'b0, 16'd0,     1'b0, 16'd13};
        vt[6]  = '{1'b0, 1'b0, 16'd0,     1'b0, 16'd17};
        vt[7]  = '{1'b0, 1'b0, 16'd0,     1'b0, 16'd19};
        vt[8]  = '{1'b1, 1'b0, 16'd100,   1'b0, 16'd101};
        vt[9]  = '{1'b1, 1'b1, 16'd100,   1'b0, 16'd97};
        vt[10] = '{1'b1, 1'b0, 16'd65521, 1'b1, 16'd97};
        vt[11] = '{1'b1, 1'b1, 16'd65535, 1'b0, 16'd65521};
        vt[12] = '{1'b1, 1'b1, 16'd2,     1'b1, 16'd65521};
        vt[13] = '{1'b1, 1'b1, 16'd3,     1'b0, 16'd2};
        vt[14] = '{1'b1, 1'b0, 16'd65535, 1'b1, 16'd2};

        rst = 1'b1;
        go16 = 1'b0; load16 = 1'b0; down16 = 1'b0; from16 = '0;
        go8  = 1'b0; load8  = 1'b0; down8  = 1'b0; from8  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", int'(ready16), 1);
        chk("reset_error", int'(error16), 0);
        chk("reset_res",   int'(res16),   1);

        for (int i = 0; i < 15; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            start16(nm, vt[i].load, vt[i].down, vt[i].from);
            wait16(nm);
            chk({nm, "_error"}, int'(error16), int'(vt[i].exp_err));
            chk({nm, "_res"},   int'(res16),   int'(vt[i].exp_res));
        end

        // Edges while busy are ignored; go held high afterwards starts nothing.
        start16("ignore", 1'b1, 1'b0, 16'd100);
        repeat (3) @(negedge clk);
        load16 = 1'b1; down16 = 1'b1; from16 = 16'd200; go16 = 1'b1;
        @(negedge clk);
        chk("ignore_still_busy", int'(ready16), 0);
        wait16("ignore");
        chk("ignore_res",   int'(res16),   101);
        chk("ignore_error", int'(error16), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("ignore_held_ready%0d", k), int'(ready16), 1);
        end
        go16 = 1'b0;

        // Reset in the middle of a search abandons it.
        start16("midrst", 1'b1, 1'b1, 16'd65535);
        repeat (30) @(negedge clk);
        chk("midrst_searching", int'(ready16), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", int'(ready16), 1);
        chk("midrst_error", int'(error16), 0);
        chk("midrst_res",   int'(res16),   1);

        // Follow-up after reset: seed 1 searched upward gives 2.
        start16("postrst", 1'b0, 1'b0, 16'd0);
        wait16("postrst");
        chk("postrst_res", int'(res16), 2);

        mres = 1;
        for (int b = 1; b <= 255; b++) begin
            for (int d = 0; d < 2; d++) begin
                string nm;
                nm = $sformatf("sweep_b%0d_d%0d", b, d);
                exp_p = ref_seek8(b, d[0]);
                start8(nm, 1'b1, d[0], b[7:0]);
                wait8(nm);
                if (exp_p < 0) begin
                    chk({nm, "_error"}, int'(error8), 1);
                end else begin
                    chk({nm, "_error"}, int'(error8), 0);
                    mres = exp_p;
                end
                chk({nm, "_res"}, int'(res8), mres);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
